// File: rtl/ysyx_24080006_icache_assoc.sv
// Set-associative instruction cache between the IFU and an AXI4 read port.
// Register-array storage, INCR burst refill, per-set round-robin replacement and fence.i flush.
module ysyx_24080006_icache_assoc #(
   parameter int WAYS   = 2,
   parameter int SETS_W = 4,
   parameter int LINE_W = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_req_addr,
   output logic        ifu_rsp_valid,
   output logic [31:0] ifu_rsp_inst,
   output logic        ifu_rsp_err,
   input  logic        fence_i,
   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   input  logic        rvalid,
   output logic        rready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   output logic        perf_hit,
   output logic        perf_miss,
   output logic [2:0]  dbg_state
);

   localparam int TAG_W = 32 - 2 - LINE_W - SETS_W;
   localparam int SETS  = 1 << SETS_W;
   localparam int WORDS = 1 << LINE_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOOKUP  = 3'd1,
      S_MISS_AR = 3'd2,
      S_REFILL  = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic              valid_q [WAYS][SETS];
   logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
   logic [31:0]       data_q  [WAYS][SETS][WORDS];
   logic [WAY_W-1:0]  rr_q    [SETS];

   logic [31:0]       req_addr_q;
   logic [WAY_W-1:0]  victim_q;
   logic [LINE_W-1:0] beat_q;
   logic              err_q;
   logic [31:0]       buf_q;
   logic              fence_pend_q;

   logic [TAG_W-1:0]  req_tag;
   logic [SETS_W-1:0] req_idx;
   logic [LINE_W-1:0] req_woff;
   logic              aligned;
   logic              tag_hit;
   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic [31:0]       hit_word;
   logic [WAY_W-1:0]  victim;
   logic              inv_found;
   logic              req_ready;
   logic              accept;
   logic              beat_fire;
   logic              last_beat;
   logic              beat_err;
   logic              burst_end;
   logic              err_now;
   logic              flush;
   logic              miss_start;

   assign req_tag   = req_addr_q[31 -: TAG_W];
   assign req_idx   = req_addr_q[LINE_W+2 +: SETS_W];
   assign req_woff  = req_addr_q[2 +: LINE_W];
   assign aligned   = (req_addr_q[1:0] == 2'b00);
   assign hit       = tag_hit & aligned;
   assign dbg_state = state_q;

   // Hit detection and victim selection: lowest invalid way, else the set's RR pointer.
   always_comb begin
      tag_hit   = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      victim    = rr_q[req_idx];
      for (int w = 0; w < WAYS; w++) begin
         if (!tag_hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
            tag_hit = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!inv_found && !valid_q[w][req_idx]) begin
            inv_found = 1'b1;
            victim    = WAY_W'(w);
         end
      end
      hit_word = data_q[hit_way][req_idx][req_woff];
   end

   assign beat_fire  = (state_q == S_REFILL) & rvalid;
   assign last_beat  = (beat_q == {LINE_W{1'b1}});
   assign beat_err   = (rresp != 2'b00) | (rlast != last_beat);
   assign burst_end  = beat_fire & (rlast | last_beat);
   assign err_now    = err_q | beat_err;
   assign miss_start = (state_q == S_LOOKUP) & aligned & ~tag_hit;
   assign flush      = (fence_i & ((state_q == S_IDLE) | (state_q == S_LOOKUP))) |
                       (fence_pend_q & (state_q == S_IDLE));

   // valid/ready: a transfer happens on the rising edge where both are high;
   // the initiator holds valid and its payload stable until that edge.
   always_comb begin
      state_d       = state_q;
      req_ready     = 1'b0;
      ifu_rsp_valid = 1'b0;
      ifu_rsp_inst  = 32'd0;
      ifu_rsp_err   = 1'b0;
      perf_hit      = 1'b0;
      perf_miss     = 1'b0;
      arvalid       = 1'b0;
      rready        = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = ~fence_pend_q;
            if (ifu_req_valid & req_ready) state_d = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (!aligned) begin
               ifu_rsp_valid = 1'b1;
               ifu_rsp_err   = 1'b1;
               state_d       = S_IDLE;
            end else if (hit) begin
               ifu_rsp_valid = 1'b1;
               ifu_rsp_inst  = hit_word;
               perf_hit      = 1'b1;
               req_ready     = ~fence_pend_q;
               state_d       = (ifu_req_valid & req_ready) ? S_LOOKUP : S_IDLE;
            end else begin
               perf_miss = 1'b1;
               state_d   = S_MISS_AR;
            end
         end
         S_MISS_AR: begin
            arvalid = 1'b1;
            if (arready) state_d = S_REFILL;
         end
         S_REFILL: begin
            rready = 1'b1;
            if (burst_end) state_d = S_RESP;
         end
         S_RESP: begin
            ifu_rsp_valid = 1'b1;
            ifu_rsp_err   = err_q;
            ifu_rsp_inst  = err_q ? 32'd0 : buf_q;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ifu_req_ready = req_ready;
   assign accept        = ifu_req_valid & req_ready;

   // AR payload is gated by arvalid so the port reads all-zero while idle.
   assign araddr  = arvalid ? {req_addr_q[31:LINE_W+2], {(LINE_W+2){1'b0}}} : 32'd0;
   assign arlen   = arvalid ? 8'(WORDS - 1) : 8'd0;
   assign arsize  = arvalid ? 3'b010 : 3'b000;
   assign arburst = arvalid ? 2'b01 : 2'b00;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         req_addr_q   <= '0;
         victim_q     <= '0;
         beat_q       <= '0;
         err_q        <= 1'b0;
         buf_q        <= '0;
         fence_pend_q <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            rr_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               valid_q[w][s] <= 1'b0;
               tag_q[w][s]   <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         if (accept) req_addr_q <= ifu_req_addr;
         if (miss_start) begin
            victim_q <= victim;
            beat_q   <= '0;
            err_q    <= 1'b0;
         end
         if (beat_fire) begin
            beat_q <= beat_q + 1'b1;
            if (beat_err) err_q <= 1'b1;
            if (beat_q == req_woff) buf_q <= rdata;
         end
         if (fence_i & ((state_q == S_MISS_AR) | (state_q == S_REFILL) | (state_q == S_RESP)))
            fence_pend_q <= 1'b1;
         else if (state_q == S_IDLE)
            fence_pend_q <= 1'b0;
         if (burst_end & ~err_now) begin
            valid_q[victim_q][req_idx] <= 1'b1;
            tag_q[victim_q][req_idx]   <= req_tag;
            rr_q[req_idx] <= (rr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;
         end
         if (flush) begin
            for (int s = 0; s < SETS; s++)
               for (int w = 0; w < WAYS; w++)
                  valid_q[w][s] <= 1'b0;
         end
      end
   end

   // Line data needs no reset: it is only read once its valid bit is set.
   always_ff @(posedge clock) begin
      if (beat_fire) data_q[victim_q][req_idx][beat_q] <= rdata;
   end

endmodule
